// File: rtl/dcache_load_requester_if.sv
// Dcache load port bundle: request struct driven by the requester, response
// struct driven by the cache.
interface dcache_load_requester_if #(
    parameter int INDEX_W = 12,
    parameter int TAG_W   = 44
);

    typedef struct packed {
        logic [INDEX_W-1:0] address_index;
        logic [TAG_W-1:0]   address_tag;
        logic [63:0]        data_wdata;
        logic               data_req;
        logic               data_we;
        logic [7:0]         data_be;
        logic [1:0]         data_size;
        logic               kill_req;
        logic               tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [63:0] data_rdata;
    } dcache_req_o_t;

    dcache_req_i_t req_port_o;
    dcache_req_o_t req_port_i;

    modport master (output req_port_o, input req_port_i);
    modport slave  (input req_port_o, output req_port_i);

endinterface

// File: rtl/dcache_load_requester.sv
// Single-outstanding load requester for one dcache load port: index phase,
// grant, tag phase, rvalid, then an aligned zero-extended result.
//
// Handshakes: a command transfers on a rising edge where cmd_valid_i and
// cmd_ready_o are both 1; a result transfers on a rising edge where
// rsp_valid_o and rsp_ready_i are both 1. Once raised, rsp_valid_o and its
// data stay stable until the transfer or a kill.
module dcache_load_requester #(
    parameter int INDEX_W = 12,
    parameter int TAG_W   = 44,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [TAG_W+INDEX_W-1:0] cmd_addr_i,
    input  logic [1:0]               cmd_size_i,
    input  logic                     kill_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [63:0]              rsp_data_o,
    output logic                     rsp_err_o,
    dcache_load_requester_if.master  dc,
    output logic                     err_sticky_o,
    output logic [2:0]               dbg_state_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_TAG  = 3'd2,
        S_WAIT = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t             state_q;
    logic [INDEX_W-1:0] index_q;
    logic [TAG_W-1:0]   tag_q;
    logic [7:0]         be_q;
    logic [1:0]         size_q;
    logic [2:0]         off_q;
    logic               kill_q;
    logic               discard_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [63:0]        rsp_data_q;
    logic               rsp_err_q;
    logic               err_sticky_q;

    logic [7:0]  be_base;
    logic [2:0]  align_mask;
    logic [7:0]  be_next;
    logic        misaligned;
    logic [63:0] shifted;
    logic [63:0] aligned;

    // Decode the incoming command: byte enables and the alignment check.
    always_comb begin
        be_base    = 8'hFF;
        align_mask = 3'b111;
        case (cmd_size_i)
            2'd0: begin be_base = 8'h01; align_mask = 3'b000; end
            2'd1: begin be_base = 8'h03; align_mask = 3'b001; end
            2'd2: begin be_base = 8'h0F; align_mask = 3'b011; end
            default: begin be_base = 8'hFF; align_mask = 3'b111; end
        endcase
        be_next    = be_base << cmd_addr_i[2:0];
        misaligned = (cmd_addr_i[2:0] & align_mask) != 3'b000;
    end

    // Move the returned doubleword down to bit 0 and zero-extend to the load size.
    always_comb begin
        shifted = dc.req_port_i.data_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    aligned = {56'd0, shifted[7:0]};
            2'd1:    aligned = {48'd0, shifted[15:0]};
            2'd2:    aligned = {32'd0, shifted[31:0]};
            default: aligned = shifted;
        endcase
    end

    // Load sequencer: state, latched command, timeout counter and result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            index_q      <= '0;
            tag_q        <= '0;
            be_q         <= '0;
            size_q       <= '0;
            off_q        <= '0;
            kill_q       <= 1'b0;
            discard_q    <= 1'b0;
            cnt_q        <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            // Any rvalid outside WAIT (including the tag cycle) or grant outside REQ is a protocol violation.
            if ((dc.req_port_i.data_rvalid && state_q != S_WAIT) ||
                (dc.req_port_i.data_gnt && state_q != S_REQ)) begin
                err_sticky_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        index_q   <= cmd_addr_i[INDEX_W-1:0];
                        tag_q     <= cmd_addr_i[TAG_W+INDEX_W-1:INDEX_W];
                        be_q      <= be_next;
                        size_q    <= cmd_size_i;
                        off_q     <= cmd_addr_i[2:0];
                        kill_q    <= 1'b0;
                        discard_q <= 1'b0;
                        if (misaligned) begin
                            rsp_data_q <= '0;
                            rsp_err_q  <= 1'b1;
                            state_q    <= S_RESP;
                        end else begin
                            state_q <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // A grant in the same cycle as a kill wins; the kill is carried into the tag phase.
                    if (dc.req_port_i.data_gnt) begin
                        kill_q  <= kill_i;
                        state_q <= S_TAG;
                    end else if (kill_i) begin
                        state_q <= S_IDLE;
                    end
                end
                S_TAG: begin
                    if (kill_i || kill_q) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (kill_i) begin
                        discard_q <= 1'b1;
                    end
                    if (dc.req_port_i.data_rvalid) begin
                        if (discard_q || kill_i) begin
                            state_q <= S_IDLE;
                        end else begin
                            rsp_data_q <= aligned;
                            rsp_err_q  <= 1'b0;
                            state_q    <= S_RESP;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        if (discard_q || kill_i) begin
                            state_q <= S_IDLE;
                        end else begin
                            rsp_data_q <= '0;
                            rsp_err_q  <= 1'b1;
                            state_q    <= S_RESP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (kill_i || rsp_ready_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Assemble the cache request; kill_req follows kill_i within the tag cycle.
    always_comb begin
        dc.req_port_o               = '0;
        dc.req_port_o.address_index = index_q;
        dc.req_port_o.address_tag   = tag_q;
        dc.req_port_o.data_be       = be_q;
        dc.req_port_o.data_size     = size_q;
        dc.req_port_o.data_req      = (state_q == S_REQ);
        dc.req_port_o.tag_valid     = (state_q == S_TAG);
        dc.req_port_o.kill_req      = (state_q == S_TAG) && (kill_i || kill_q);
    end

    assign cmd_ready_o  = (state_q == S_IDLE) && !rst_i;
    assign rsp_valid_o  = (state_q == S_RESP);
    assign rsp_data_o   = rsp_data_q;
    assign rsp_err_o    = rsp_err_q;
    assign err_sticky_o = err_sticky_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dcache_load_requester.sv
// Directed bench for dcache_load_requester with a small scripted cache responder.
module tb_dcache_load_requester;

    localparam int INDEX_W = 12;
    localparam int TAG_W   = 44;
    localparam int AW      = TAG_W + INDEX_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [1:0]    cmd_size = '0;
    logic          kill = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [63:0]   rsp_data;
    logic          rsp_err;
    logic          err_sticky;
    logic [2:0]    dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] exp_q[$];
    logic [7:0]  exp_be_q[$];

    dcache_load_requester_if #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) dcif ();

    dcache_load_requester #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_addr_i(cmd_addr), .cmd_size_i(cmd_size), .kill_i(kill),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_err_o(rsp_err), .dc(dcif), .err_sticky_o(err_sticky), .dbg_state_o(dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver: one load with a scripted cache; rv_wait counts WAIT cycles before rvalid.
    task automatic do_load(input logic [AW-1:0] addr, input logic [1:0] size, input int gnt_wait,
                           input int rv_wait, input logic [63:0] rdata, output int lat,
                           output int req_cycles, output logic [7:0] be_seen, output logic const_seen,
                           output logic got_rsp, output logic [63:0] data, output logic err);
        int gcnt;
        int wcnt;
        lat = -1; req_cycles = 0; be_seen = '0; const_seen = 1'b0;
        got_rsp = 1'b0; data = '0; err = 1'b0; gcnt = 0; wcnt = -1;
        cmd_valid = 1'b1; cmd_addr = addr; cmd_size = size;
        for (int cyc = 0; cyc < 64; cyc++) begin
            dcif.req_port_i = '0;
            if (dcif.req_port_o.data_we || dcif.req_port_o.data_wdata != 64'd0) const_seen = 1'b1;
            if (rsp_valid) begin
                got_rsp = 1'b1; data = rsp_data; err = rsp_err; lat = cyc;
                break;
            end
            if (dcif.req_port_o.data_req) begin
                req_cycles++;
                be_seen = dcif.req_port_o.data_be;
                if (gcnt == gnt_wait) dcif.req_port_i.data_gnt = 1'b1;
                gcnt++;
            end
            if (dcif.req_port_o.tag_valid) begin
                wcnt = 0;
            end else if (wcnt >= 0) begin
                if (wcnt == rv_wait) begin
                    dcif.req_port_i.data_rvalid = 1'b1;
                    dcif.req_port_i.data_rdata  = rdata;
                end
                wcnt++;
            end
            step();
            cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        dcif.req_port_i = '0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got %b exp 0", cmd_ready); end
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== 64'd0) begin n_fail++; $display("FAIL rst_rsp: got v%b e%b d%h exp 0", rsp_valid, rsp_err, rsp_data); end
        n_cmp++; if (dcif.req_port_o !== '0) begin n_fail++; $display("FAIL rst_req_port: got %h exp 0", dcif.req_port_o); end
        n_cmp++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL rst_sticky: got %b exp 0", err_sticky); end
        rst = 1'b0;
        #1;
        n_cmp++; if (cmd_ready !== 1'b1 || dbg_state !== 3'd0) begin n_fail++; $display("FAIL rst_idle: got rdy%b st%0d exp rdy1 st0", cmd_ready, dbg_state); end
    endtask

    task automatic test_aligned_dword();
        int lat; int rc; logic [7:0] be; logic cs; logic got; logic [63:0] d; logic e;
        do_load(56'h1000_0008, 2'd3, 0, 0, 64'hDEAD_BEEF_0123_4567, lat, rc, be, cs, got, d, e);
        n_cmp++; if (got !== 1'b1 || d !== 64'hDEAD_BEEF_0123_4567 || e !== 1'b0) begin n_fail++; $display("FAIL dword_rsp: got v%b d%h e%b exp v1 dDEADBEEF01234567 e0", got, d, e); end
        n_cmp++; if (be !== 8'hFF) begin n_fail++; $display("FAIL dword_be: got %h exp ff", be); end
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL dword_latency: got %0d exp 4", lat); end
        n_cmp++; if (dcif.req_port_o.address_index !== 12'h008 || dcif.req_port_o.address_tag !== 44'h1_0000) begin n_fail++; $display("FAIL dword_addr: got i%h t%h exp i008 t10000", dcif.req_port_o.address_index, dcif.req_port_o.address_tag); end
        n_cmp++; if (cs !== 1'b0) begin n_fail++; $display("FAIL dword_const_fields: got %b exp 0", cs); end
        consume();
        n_cmp++; if (dbg_state !== 3'd0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL dword_release: got st%0d v%b exp st0 v0", dbg_state, rsp_valid); end
    endtask

    task automatic test_half_slow_gnt();
        int lat; int rc; logic [7:0] be; logic cs; logic got; logic [63:0] d; logic e;
        do_load(56'h0000_2346, 2'd1, 3, 2, 64'hABCD_0000_0000_0000, lat, rc, be, cs, got, d, e);
        n_cmp++; if (rc !== 4) begin n_fail++; $display("FAIL half_req_cycles: got %0d exp 4", rc); end
        n_cmp++; if (be !== 8'hC0) begin n_fail++; $display("FAIL half_be: got %h exp c0", be); end
        n_cmp++; if (got !== 1'b1 || d !== 64'h0000_0000_0000_ABCD || e !== 1'b0) begin n_fail++; $display("FAIL half_rsp: got v%b d%h e%b exp v1 dabcd e0", got, d, e); end
        n_cmp++; if (lat !== 9) begin n_fail++; $display("FAIL half_latency: got %0d exp 9", lat); end
        consume();
    endtask

    task automatic test_misaligned();
        int lat; int rc; logic [7:0] be; logic cs; logic got; logic [63:0] d; logic e;
        do_load(56'h0000_0401, 2'd2, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, lat, rc, be, cs, got, d, e);
        n_cmp++; if (rc !== 0) begin n_fail++; $display("FAIL misal_no_req: got %0d exp 0", rc); end
        n_cmp++; if (got !== 1'b1 || e !== 1'b1 || d !== 64'd0) begin n_fail++; $display("FAIL misal_rsp: got v%b e%b d%h exp v1 e1 d0", got, e, d); end
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL misal_latency: got %0d exp 1", lat); end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [4] = '{56'h0103, 56'h0204, 56'h0302, 56'h0400};
        logic [1:0]    sizes [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
        logic [63:0]   rdat  [4] = '{64'h1122_3344_5566_7788, 64'hCAFE_F00D_1234_5678,
                                     64'h1122_3344_5566_7788, 64'h0F0E_0D0C_0B0A_0908};
        int lat; int rc; logic [7:0] be; logic cs; logic got; logic [63:0] d; logic e;
        logic [63:0] ed; logic [7:0] eb;
        exp_q.push_back(64'h55);                 exp_be_q.push_back(8'h08);
        exp_q.push_back(64'hCAFE_F00D);          exp_be_q.push_back(8'hF0);
        exp_q.push_back(64'h5566);               exp_be_q.push_back(8'h0C);
        exp_q.push_back(64'h0F0E_0D0C_0B0A_0908); exp_be_q.push_back(8'hFF);
        for (int i = 0; i < 4; i++) begin
            do_load(addrs[i], sizes[i], i % 2, i % 3, rdat[i], lat, rc, be, cs, got, d, e);
            ed = exp_q.pop_front();
            eb = exp_be_q.pop_front();
            n_cmp++; if (got !== 1'b1 || d !== ed || e !== 1'b0) begin n_fail++; $display("FAIL b2b_data[%0d]: got v%b d%h e%b exp v1 d%h e0", i, got, d, e, ed); end
            n_cmp++; if (be !== eb) begin n_fail++; $display("FAIL b2b_be[%0d]: got %h exp %h", i, be, eb); end
            consume();
        end
    endtask

    task automatic test_kill_req();
        cmd_valid = 1'b1; cmd_addr = 56'h0500; cmd_size = 2'd3;
        step();
        cmd_valid = 1'b0; kill = 1'b1;
        #1;
        n_cmp++; if (dcif.req_port_o.data_req !== 1'b1) begin n_fail++; $display("FAIL killreq_req_on: got %b exp 1", dcif.req_port_o.data_req); end
        step();
        kill = 1'b0;
        n_cmp++; if (dbg_state !== 3'd0 || dcif.req_port_o.data_req !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL killreq_idle: got st%0d r%b v%b exp st0 r0 v0", dbg_state, dcif.req_port_o.data_req, rsp_valid); end
        // kill and grant together: grant wins, kill carried into the tag cycle
        cmd_valid = 1'b1; cmd_addr = 56'h0508;
        step();
        cmd_valid = 1'b0; kill = 1'b1; dcif.req_port_i.data_gnt = 1'b1;
        step();
        kill = 1'b0; dcif.req_port_i.data_gnt = 1'b0;
        #1;
        n_cmp++; if (dbg_state !== 3'd2 || dcif.req_port_o.kill_req !== 1'b1) begin n_fail++; $display("FAIL killgnt_tag: got st%0d k%b exp st2 k1", dbg_state, dcif.req_port_o.kill_req); end
        step();
        n_cmp++; if (dbg_state !== 3'd0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL killgnt_idle: got st%0d v%b exp st0 v0", dbg_state, rsp_valid); end
    endtask

    task automatic test_kill_wait();
        cmd_valid = 1'b1; cmd_addr = 56'h0510; cmd_size = 2'd3;
        step();
        cmd_valid = 1'b0; dcif.req_port_i.data_gnt = 1'b1;
        step();
        dcif.req_port_i.data_gnt = 1'b0;
        step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        n_cmp++; if (dbg_state !== 3'd3) begin n_fail++; $display("FAIL killwait_still_wait: got %0d exp 3", dbg_state); end
        dcif.req_port_i.data_rvalid = 1'b1; dcif.req_port_i.data_rdata = 64'h1234;
        step();
        dcif.req_port_i = '0;
        n_cmp++; if (dbg_state !== 3'd0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL killwait_discard: got st%0d v%b exp st0 v0", dbg_state, rsp_valid); end
        n_cmp++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL killwait_sticky: got %b exp 0", err_sticky); end
    endtask

    task automatic test_kill_tag();
        logic seen_valid;
        cmd_valid = 1'b1; cmd_addr = 56'h0608; cmd_size = 2'd3;
        step();
        cmd_valid = 1'b0; dcif.req_port_i.data_gnt = 1'b1;
        step();
        dcif.req_port_i.data_gnt = 1'b0; kill = 1'b1;
        #1;
        n_cmp++; if (dcif.req_port_o.kill_req !== 1'b1 || dcif.req_port_o.tag_valid !== 1'b1) begin n_fail++; $display("FAIL killtag_kill_req: got k%b t%b exp k1 t1", dcif.req_port_o.kill_req, dcif.req_port_o.tag_valid); end
        step();
        kill = 1'b0;
        n_cmp++; if (dbg_state !== 3'd0 || dcif.req_port_o.kill_req !== 1'b0) begin n_fail++; $display("FAIL killtag_idle: got st%0d k%b exp st0 k0", dbg_state, dcif.req_port_o.kill_req); end
        seen_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid) seen_valid = 1'b1;
            step();
        end
        n_cmp++; if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL killtag_no_rsp: got %b exp 0", seen_valid); end
        dcif.req_port_i.data_rvalid = 1'b1; dcif.req_port_i.data_rdata = 64'h99;
        step();
        dcif.req_port_i = '0;
        n_cmp++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL killtag_stray_sticky: got %b exp 1", err_sticky); end
    endtask

    task automatic test_timeout();
        int lat; int rc; logic [7:0] be; logic cs; logic got; logic [63:0] d; logic e;
        do_load(56'h0710, 2'd3, 0, 1000, 64'hFFFF, lat, rc, be, cs, got, d, e);
        n_cmp++; if (got !== 1'b1 || e !== 1'b1 || d !== 64'd0) begin n_fail++; $display("FAIL timeout_rsp: got v%b e%b d%h exp v1 e1 d0", got, e, d); end
        n_cmp++; if (lat !== 11) begin n_fail++; $display("FAIL timeout_latency: got %0d exp 11", lat); end
        step();
        n_cmp++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL timeout_hold: got v%b rdy%b exp v1 rdy0", rsp_valid, cmd_ready); end
        consume();
        do_load(56'h0718, 2'd2, 0, 0, 64'h0000_0000_ABCD_1234, lat, rc, be, cs, got, d, e);
        n_cmp++; if (got !== 1'b1 || d !== 64'hABCD_1234 || e !== 1'b0) begin n_fail++; $display("FAIL timeout_next: got v%b d%h e%b exp v1 dabcd1234 e0", got, d, e); end
        consume();
    endtask

    task automatic test_reset_mid_wait();
        int lat; int rc; logic [7:0] be; logic cs; logic got; logic [63:0] d; logic e;
        cmd_valid = 1'b1; cmd_addr = 56'h0808; cmd_size = 2'd3;
        step();
        cmd_valid = 1'b0; dcif.req_port_i.data_gnt = 1'b1;
        step();
        dcif.req_port_i.data_gnt = 1'b0;
        step();
        n_cmp++; if (dbg_state !== 3'd3) begin n_fail++; $display("FAIL rstwait_in_wait: got %0d exp 3", dbg_state); end
        rst = 1'b1;
        #1;
        n_cmp++; if (dbg_state !== 3'd0 || dcif.req_port_o !== '0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rstwait_outputs: got st%0d req%h v%b rdy%b exp all 0", dbg_state, dcif.req_port_o, rsp_valid, cmd_ready); end
        n_cmp++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL rstwait_sticky_clear: got %b exp 0", err_sticky); end
        step();
        rst = 1'b0;
        dcif.req_port_i.data_rvalid = 1'b1; dcif.req_port_i.data_rdata = 64'h55AA;
        step();
        dcif.req_port_i = '0;
        n_cmp++; if (err_sticky !== 1'b1 || dbg_state !== 3'd0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstwait_stray: got s%b st%0d v%b exp s1 st0 v0", err_sticky, dbg_state, rsp_valid); end
        do_load(56'h0900, 2'd3, 0, 0, 64'h0123_4567_89AB_CDEF, lat, rc, be, cs, got, d, e);
        n_cmp++; if (got !== 1'b1 || d !== 64'h0123_4567_89AB_CDEF || e !== 1'b0) begin n_fail++; $display("FAIL rstwait_next_load: got v%b d%h e%b exp v1 d0123456789abcdef e0", got, d, e); end
        consume();
    endtask

    // Test sequence and final report
    initial begin
        dcif.req_port_i = '0;
        test_reset();
        test_aligned_dword();
        test_half_slow_gnt();
        test_misaligned();
        test_back_to_back();
        test_kill_req();
        test_kill_wait();
        test_kill_tag();
        test_timeout();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_load_requester.md
Name: dcache_load_requester

Overview:
- Core-side initiator for one dcache load port. It drives the `dcache_req_i_t` request struct and consumes the `dcache_req_o_t` response.
- Accepts load commands on a valid/ready interface and sequences the index phase, grant, tag phase and rvalid of the cache protocol. It returns aligned, zero-extended data on a valid/ready result interface.
- Used as the active stimulus agent and as a standalone requester in the std cache subsystem bench. One outstanding load at a time.

Parameters:
- INDEX_W, 12, address index width; equals DCACHE_INDEX_WIDTH.
- TAG_W, 44, address tag width; equals DCACHE_TAG_WIDTH.
- TIMEOUT, 1024, maximum cycles from tag phase to rvalid before error; minimum 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cmd_valid_i  in  1  load command valid
- cmd_ready_o  out  1  command accepted when valid&&ready
- cmd_addr_i  in  TAG_W+INDEX_W  physical byte address
- cmd_size_i  in  2  0=byte, 1=half, 2=word, 3=dword
- kill_i  in  1  abort the current load
- rsp_valid_o  out  1  result valid, held until rsp_ready_i
- rsp_ready_i  in  1  result consumer ready
- rsp_data_o  out  64  load data shifted to bit 0, zero-extended
- rsp_err_o  out  1  result carries an error (misaligned or timeout)
- req_port_o  out  dcache_req_i_t  request to the dcache
- req_port_i  in  dcache_req_o_t  response from the dcache
- err_sticky_o  out  1  protocol violation seen; cleared only by reset

Behaviour:
- **Reset**
  - FSM goes to IDLE.
  - All outputs are 0, including every `req_port_o` field and err_sticky_o.
  - Reset mid-transaction abandons the load immediately, with no kill_req.
- **Constant request fields:** data_we=0 and data_wdata=0 at all times.
- **Latched on command accept:** address_index = addr[INDEX_W-1:0]; address_tag = addr[TAG_W+INDEX_W-1:INDEX_W]; data_size = size; data_be = ((1<<(1<<size))-1) << addr[2:0].
- **Misaligned command:** addr[2:0] not a multiple of 2^size. The command is accepted, there is no cache access, and the FSM goes to RESP with rsp_err_o=1 and rsp_data_o=0.
- **FSM states:** IDLE, REQ, TAG, WAIT, RESP.
  - IDLE:
    - cmd_ready_o=1, combinational to state only.
    - On cmd_valid_i: latch the command, go to REQ (or to RESP if misaligned).
    - kill_i is ignored.
  - REQ:
    - data_req=1 with index, be and size stable.
    - data_gnt=1 → TAG.
    - kill_i=1 without data_gnt → drop data_req, go to IDLE with no response.
    - If kill_i and data_gnt are both 1 in the same cycle, the grant wins → TAG with the kill latched.
  - TAG:
    - Exactly one cycle; tag_valid=1 with address_tag driven.
    - If kill_i is 1 now, or a kill was latched in REQ: kill_req=1 in the same cycle, go to IDLE, no response.
    - Otherwise go to WAIT and start the timeout counter at 0.
    - data_rvalid in this cycle is a violation: set err_sticky_o and ignore the data.
  - WAIT:
    - The counter increments each cycle.
    - data_rvalid=1 → capture data_rdata, go to RESP.
    - kill_i in WAIT sets a discard flag. On rvalid the FSM then goes to IDLE without a response.
    - Counter reaching TIMEOUT-1 with no rvalid → RESP with rsp_err_o=1 and rsp_data_o=0. A kill-discard timeout goes to IDLE instead.
  - RESP:
    - rsp_valid_o=1; rsp_data_o = (rdata >> 8*addr[2:0]) masked to 8<<size bits.
    - The result is held stable until rsp_ready_i; valid&&ready → IDLE.
    - kill_i in RESP drops the result and goes to IDLE.
- **Stray responses:** data_rvalid while not in WAIT, or data_gnt while not in REQ, sets err_sticky_o.
- **Latency:** best-case throughput is one load per 5 cycles (IDLE→REQ→TAG→WAIT→RESP with a 0-cycle consumer).
- **Back-to-back commands:** there is no bypass; a new command is accepted only in IDLE.

Test Plan:
- addr=0x1000_0008, size=3, gnt on first REQ cycle, rvalid 1 cycle after TAG with rdata=0xDEAD_BEEF_0123_4567 → data_be=0xFF, rsp_data_o=0xDEADBEEF01234567, rsp_err_o=0, rsp_valid_o 4 cycles after accept.
- addr index low bits 3'b110, size=1, gnt after 3 wait cycles, rdata=0xABCD_0000_0000_0000 → data_req held 4 cycles, data_be=0xC0, rsp_data_o=0xABCD.
- addr[2:0]=3'b001, size=2 → no data_req ever asserted, rsp_valid_o=1, rsp_err_o=1, rsp_data_o=0.
- kill_i asserted in the TAG cycle → kill_req=1 that cycle, no rsp_valid_o. A later rvalid sets err_sticky_o=1.
- TIMEOUT=8, gnt given, rvalid never given → rsp_err_o=1 with rsp_valid_o; next command accepted after rsp_ready_i.
- rst_i pulsed while in WAIT, then rvalid returned → all outputs 0, FSM in IDLE, err_sticky_o=1 from the stray rvalid; next load completes normally.
